// File: rtl/sort_three_floats_serial.sv
// Serial three-float sorter: loads three floats over valid/ready, sorts them with a single
// shared less-or-equal comparator stepped by an FSM, then streams the sorted triple out.
// Optional macro SORT_THREE_FLOATS_SERIAL_DESCENDING_EN reverses the output order.
// FLEN defaults to 64 (IEEE binary64) when not supplied by the build.

`ifndef FLEN
`define FLEN 64
`endif

// IEEE a <= b. A NaN operand raises err and returns res=0.
module f_less_or_equal (
  input  logic [`FLEN-1:0] a,
  input  logic [`FLEN-1:0] b,
  output logic             res,
  output logic             err
);
  localparam int unsigned ExpW = (`FLEN == 32) ? 8 : 11;
  localparam int unsigned ManW = `FLEN - 1 - ExpW;

  logic             a_nan, b_nan, a_sgn, b_sgn;
  logic [`FLEN-2:0] a_mag, b_mag;

  assign a_sgn = a[`FLEN-1];
  assign b_sgn = b[`FLEN-1];
  assign a_mag = a[`FLEN-2:0];
  assign b_mag = b[`FLEN-2:0];
  assign a_nan = (&a[`FLEN-2 -: ExpW]) && (|a[ManW-1:0]);
  assign b_nan = (&b[`FLEN-2 -: ExpW]) && (|b[ManW-1:0]);

  // Sign-magnitude ordering; +0 and -0 compare equal.
  always_comb begin
    err = a_nan || b_nan;
    res = 1'b0;
    if (err) begin
      res = 1'b0;
    end else if ((a_mag == '0) && (b_mag == '0)) begin
      res = 1'b1;
    end else if (a_sgn != b_sgn) begin
      res = a_sgn;
    end else if (!a_sgn) begin
      res = (a_mag <= b_mag);
    end else begin
      res = (a_mag >= b_mag);
    end
  end
endmodule

module sort_three_floats_serial (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [`FLEN-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [`FLEN-1:0] out_data,
  output logic             out_last,
  output logic             out_err,
  output logic             busy
);
  typedef enum logic [2:0] {StLoad, StC01a, StC12, StC01b, StSend} state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q;
  logic [`FLEN-1:0] r0_q, r1_q, r2_q;
  logic             err_acc_q;
  logic [`FLEN-1:0] cmp_a, cmp_b;
  logic             cmp_res, cmp_err;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // C12 compares {r1,r2}; the other compare states share {r0,r1}.
  assign cmp_a = (state_q == StC12) ? r1_q : r0_q;
  assign cmp_b = (state_q == StC12) ? r2_q : r1_q;

  f_less_or_equal u_cmp (
    .a   (cmp_a),
    .b   (cmp_b),
    .res (cmp_res),
    .err (cmp_err)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StLoad;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (in_fire && (cnt_q == 2'd2)) state_d = StC01a;
      StC01a:  state_d = StC12;
      StC12:   state_d = StC01b;
      StC01b:  state_d = StSend;
      StSend:  if (out_fire && (cnt_q == 2'd2)) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  // Output decode.
  always_comb begin
    in_ready  = (state_q == StLoad);
    out_valid = (state_q == StSend);
    out_last  = (state_q == StSend) && (cnt_q == 2'd2);
    out_err   = (state_q == StSend) && err_acc_q;
    busy      = (state_q != StLoad) || (cnt_q != 2'd0);
    out_data  = '0;
    if (state_q == StSend) begin
`ifdef SORT_THREE_FLOATS_SERIAL_DESCENDING_EN
      case (cnt_q)
        2'd0:    out_data = r2_q;
        2'd1:    out_data = r1_q;
        default: out_data = r0_q;
      endcase
`else
      case (cnt_q)
        2'd0:    out_data = r0_q;
        2'd1:    out_data = r1_q;
        default: out_data = r2_q;
      endcase
`endif
    end
  end

  // Operand registers, beat counter and NaN accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 2'd0;
      r0_q      <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      err_acc_q <= 1'b0;
    end else begin
      case (state_q)
        StLoad: begin
          if (in_fire) begin
            case (cnt_q)
              2'd0:    r0_q <= in_data;
              2'd1:    r1_q <= in_data;
              default: r2_q <= in_data;
            endcase
            cnt_q <= (cnt_q == 2'd2) ? 2'd0 : cnt_q + 2'd1;
          end
        end
        StC01a, StC01b: begin
          if (!cmp_res) begin
            r0_q <= r1_q;
            r1_q <= r0_q;
          end
          err_acc_q <= err_acc_q | cmp_err;
        end
        StC12: begin
          if (!cmp_res) begin
            r1_q <= r2_q;
            r2_q <= r1_q;
          end
          err_acc_q <= err_acc_q | cmp_err;
        end
        StSend: begin
          if (out_fire) begin
            if (cnt_q == 2'd2) begin
              cnt_q     <= 2'd0;
              err_acc_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_three_floats_serial.sv
// Bench for sort_three_floats_serial: table of sets with scoreboarded outputs, plus
// hand sequences for latency, backpressure and mid-operation reset.
module tb_sort_three_floats_serial;
  localparam logic [63:0] P1   = 64'h3FF0000000000000;
  localparam logic [63:0] P2   = 64'h4000000000000000;
  localparam logic [63:0] P3   = 64'h4008000000000000;
  localparam logic [63:0] M1   = 64'hBFF0000000000000;
  localparam logic [63:0] M2   = 64'hC000000000000000;
  localparam logic [63:0] M3   = 64'hC008000000000000;
  localparam logic [63:0] MH   = 64'hBFE0000000000000;
  localparam logic [63:0] PZ   = 64'h0000000000000000;
  localparam logic [63:0] MZ   = 64'h8000000000000000;
  localparam logic [63:0] PINF = 64'h7FF0000000000000;
  localparam logic [63:0] MINF = 64'hFFF0000000000000;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;
  localparam int NumVec = 7;

  typedef struct packed {
    logic [2:0][63:0] din;
    logic [2:0][63:0] dout;  // ascending expectation
    logic             chk;   // data order defined
    logic             err;
  } vec_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        err;
    logic        chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        out_last;
  logic        out_err;
  logic        busy;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  vec_t vecs[NumVec];

  logic        stalled = 1'b0;
  logic [63:0] st_data;
  logic        st_last, st_err;

  sort_three_floats_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] a, b, c, x, y, z, input logic chk,
                              input logic err);
    vec_t v;
    v.din[0] = a;  v.din[1] = b;  v.din[2] = c;
    v.dout[0] = x; v.dout[1] = y; v.dout[2] = z;
    v.chk = chk;
    v.err = err;
    return v;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stalled <= 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_data", out_data, st_data);
        check("stall_flags", {62'd0, out_last, out_err}, {62'd0, st_last, st_err});
      end
      if (out_valid) check("in_ready_in_send", {63'd0, in_ready}, 64'd0);
      if (out_valid && out_ready) begin
        stalled <= 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_beat", {63'd0, out_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          if (e.chk) check("out_data", out_data, e.data);
          check("out_last", {63'd0, out_last}, {63'd0, e.last});
          check("out_err", {63'd0, out_err}, {63'd0, e.err});
        end
      end else if (out_valid) begin
        stalled <= 1'b1;
        st_data <= out_data;
        st_last <= out_last;
        st_err  <= out_err;
      end
    end
  end

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic drive_beat(input logic [63:0] d);
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("in_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic push_set(input vec_t v);
    exp_t e;
    for (int i = 0; i < 3; i++) begin
`ifdef SORT_THREE_FLOATS_SERIAL_DESCENDING_EN
      e.data = v.dout[2-i];
`else
      e.data = v.dout[i];
`endif
      e.last = (i == 2);
      e.err  = v.err;
      e.chk  = v.chk;
      sb.push_back(e);
    end
    for (int i = 0; i < 3; i++) drive_beat(v.din[i]);
  endtask

  // mode 0: always ready. mode 1: 5 cycles low then toggle, with junk on the input port.
  task automatic drain(input int mode);
    for (int c = 0; c < 200; c++) begin
      if (sb.size() == 0) break;
      if (mode == 0) begin
        out_ready = 1'b1;
      end else begin
        out_ready = (c >= 5) && c[0];
        in_valid  = 1'b1;
        in_data   = 64'hDEADBEEFDEADBEEF;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(P1, P2, P3, P1, P2, P3, 1'b1, 1'b0);
    vecs[1] = mk(P3, P2, M1, M1, P2, P3, 1'b1, 1'b0);
    vecs[2] = mk(P2, P3, P1, P1, P2, P3, 1'b1, 1'b0);
    vecs[3] = mk(MZ, PZ, M1, M1, MZ, PZ, 1'b1, 1'b0);
    vecs[4] = mk(P1, QNAN, P2, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    vecs[5] = mk(M2, M3, MH, M3, M2, MH, 1'b1, 1'b0);
    vecs[6] = mk(PINF, P1, MINF, MINF, P1, PINF, 1'b1, 1'b0);

    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    check("rst_out_err", {63'd0, out_err}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NumVec; i++) begin
      push_set(vecs[i]);
      drain(0);
    end

    // Latency: out_valid must rise after the third edge following the last input.
    out_ready = 1'b0;
    push_set(vecs[1]);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("latency_valid", {63'd0, out_valid}, (k == 3) ? 64'd1 : 64'd0);
      check("latency_busy", {63'd0, busy}, 64'd1);
    end
    @(posedge clk);
    #1;
    drain(0);

    // Backpressure with in_valid asserted during SEND.
    out_ready = 1'b0;
    push_set(vecs[2]);
    drain(1);

    // Mid-operation reset after two beats.
    drive_beat(P3);
    drive_beat(P1);
    check("partial_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_in_ready", {63'd0, in_ready}, 64'd1);
    push_set(vecs[0]);
    drain(0);

    repeat (3) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
